core_l1d_resp: RTL

//  - Responder end of the core->L1D request bus driven by the memory pipeline stage.
//  - Accepts one load/store request at a time and performs it on a local word-addressed data RAM.
//  - Returns load data right-aligned (byte/half/word) for WB sign-extension, plus an error flag.
//  - Stands in for the L1D in core-level bring-up.

---
 rtl/core_l1d_resp_pkg.sv | 53 +++++
 rtl/core_l1d_resp_if.sv | 27 ++
 rtl/core_l1d_resp_ram.sv | 31 +++
 rtl/core_l1d_resp.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/core_l1d_resp_pkg.sv
// Shared types and helpers for the core->L1D responder: request encodings,
// FSM states, byte-enable generation and load-data extraction.
package l1d_pkg;

    typedef enum logic [2:0] {L1D_RD, L1D_WR} l1d_cop_t;
    typedef enum logic [2:0] {L1D_B, L1D_H, L1D_W} l1d_size_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} l1d_resp_st_t;

    // Force the byte offset to the natural alignment of the access size.
    function automatic logic [1:0] l1d_align_off(l1d_size_t size, logic [1:0] off);
        logic [1:0] r;
        case (size)
            L1D_H:   r = {off[1], 1'b0};
            L1D_W:   r = 2'b00;
            default: r = off;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] l1d_byte_en(l1d_size_t size, logic [1:0] off);
        logic [3:0] r;
        case (size)
            L1D_B:   r = 4'b0001 << off;
            L1D_H:   r = 4'b0011 << off;
            default: r = 4'hF;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] l1d_lane_data(l1d_size_t size, logic [31:0] wdata);
        logic [31:0] r;
        case (size)
            L1D_B:   r = {4{wdata[7:0]}};
            L1D_H:   r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] l1d_extract(l1d_size_t size, logic [1:0] off,
                                                logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (size)
            L1D_B:   r = {24'h0, sh[7:0]};
            L1D_H:   r = {16'h0, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/core_l1d_resp_if.sv
// Core->L1D request/response bus. The memory stage drives it through the
// master modport; the responder (core_l1d_resp) uses the slave modport.
interface core_l1d_resp_if;

    logic        l1d_req_val_in;
    logic        l1d_req_ack_out;
    logic [2:0]  l1d_req_cop_in;
    logic [2:0]  l1d_req_size_in;
    logic [31:0] l1d_req_addr_in;
    logic [31:0] l1d_req_wdata_in;
    logic        l1d_resp_val_out;
    logic [31:0] l1d_resp_data_out;
    logic        l1d_resp_err_out;

    modport master (
        output l1d_req_val_in, l1d_req_cop_in, l1d_req_size_in,
               l1d_req_addr_in, l1d_req_wdata_in,
        input  l1d_req_ack_out, l1d_resp_val_out, l1d_resp_data_out, l1d_resp_err_out
    );

    modport slave (
        input  l1d_req_val_in, l1d_req_cop_in, l1d_req_size_in,
               l1d_req_addr_in, l1d_req_wdata_in,
        output l1d_req_ack_out, l1d_resp_val_out, l1d_resp_data_out, l1d_resp_err_out
    );

endinterface

// File: rtl/core_l1d_resp_ram.sv
// Single-port synchronous-read data RAM, DEPTH x 32 with per-byte write enable.
// Contents are intentionally not reset.
module core_l1d_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/core_l1d_resp.sv
// L1D stand-in responder: accepts one load/store at a time, performs it on a
// local RAM after LATENCY cycles. Optional macro: CORE_L1D_MISALIGN_CHK_EN.
module core_l1d_resp
    import l1d_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    core_l1d_resp_if.slave bus
);

    // state     | meaning
    // ST_IDLE   | ack high, waiting for a request
    // ST_ACCESS | request captured, latency counter running
    // ST_RESP   | one-cycle response pulse, RAM read data valid

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    l1d_resp_st_t state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         wr_q, wr_d;
    l1d_size_t    size_q, size_d;
    logic [AW-1:0] word_q, word_d;
    logic [1:0]   off_q, off_d;
    logic [31:0]  wdata_q, wdata_d;
    logic         err_q, err_d;

    logic         ack;
    logic         accept;
    logic         enter_resp;

    logic         in_wr;
    l1d_size_t    in_size;
    logic [AW-1:0] in_word;
    logic [1:0]   in_off;
    logic         in_err;

    logic         cur_wr;
    l1d_size_t    cur_size;
    logic [AW-1:0] cur_word;
    logic [1:0]   cur_off;
    logic [31:0]  cur_wdata;
    logic         cur_err;

    logic         ram_en;
    logic [3:0]   ram_we;
    logic [31:0]  ram_wdata;
    logic [31:0]  ram_rdata;

    assign ack    = (state_q == ST_IDLE);
    assign accept = bus.l1d_req_val_in && ack;

    // Decode of the incoming request; all error classification happens here.
    always_comb begin
        logic base_err;
        in_wr    = (bus.l1d_req_cop_in == L1D_WR);
        in_size  = l1d_size_t'(bus.l1d_req_size_in);
        in_word  = bus.l1d_req_addr_in[AW+1:2];
        base_err = (bus.l1d_req_cop_in > 3'd1) || (bus.l1d_req_size_in > 3'd2) ||
                   (bus.l1d_req_addr_in[31:2] >= 30'(DEPTH));
`ifdef CORE_L1D_MISALIGN_CHK_EN
        in_off   = bus.l1d_req_addr_in[1:0];
        in_err   = base_err ||
                   (bus.l1d_req_size_in == 3'd1 && bus.l1d_req_addr_in[0]) ||
                   (bus.l1d_req_size_in == 3'd2 && bus.l1d_req_addr_in[1:0] != 2'b00);
`else
        in_off   = l1d_align_off(in_size, bus.l1d_req_addr_in[1:0]);
        in_err   = base_err;
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        size_d     = size_q;
        word_d     = word_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_d    = in_wr;
                    size_d  = in_size;
                    word_d  = in_word;
                    off_d   = in_off;
                    wdata_d = bus.l1d_req_wdata_in;
                    err_d   = in_err;
                    cnt_d   = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // With LATENCY==1 the RAM access overlaps the accept cycle, so the live
    // request feeds the RAM; otherwise the captured copy does.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_wr    = in_wr;
            cur_size  = in_size;
            cur_word  = in_word;
            cur_off   = in_off;
            cur_wdata = bus.l1d_req_wdata_in;
            cur_err   = in_err;
        end else begin
            cur_wr    = wr_q;
            cur_size  = size_q;
            cur_word  = word_q;
            cur_off   = off_q;
            cur_wdata = wdata_q;
            cur_err   = err_q;
        end
        ram_en    = enter_resp && !cur_err && !rst;
        ram_we    = cur_wr ? l1d_byte_en(cur_size, cur_off) : 4'h0;
        ram_wdata = l1d_lane_data(cur_size, cur_wdata);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= L1D_B;
            word_q  <= '0;
            off_q   <= 2'b00;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            word_q  <= word_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    core_l1d_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (cur_word),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.l1d_req_ack_out   = ack;
    assign bus.l1d_resp_val_out  = (state_q == ST_RESP);
    assign bus.l1d_resp_err_out  = (state_q == ST_RESP) && err_q;
    assign bus.l1d_resp_data_out = ((state_q == ST_RESP) && !err_q && !wr_q) ?
                                   l1d_extract(size_q, off_q, ram_rdata) : 32'h0;

endmodule
